lcd_bus_sched: RTL and testbench
================================

# lcd_bus_sched

Sequencer and arbiter for the shared HD44780/LCD1602 8-bit parallel bus. Two independent requesters submit single command or data bytes over valid/ready handshakes. A round-robin arbiter picks one, and the block generates rs/dat/en with programmed setup, pulse, hold and execution-wait timing. It sits between display-content logic and the LCD pins, and replaces free-running en toggling with one enforced transaction per byte.

## Interface
Parameters (all counts in clk cycles; a value of 0 is treated as 1):
- SETUP_CYC, 4: rs/dat stable before en rises.
- PULSE_CYC, 24: en high width.
- HOLD_CYC, 4: rs/dat held after en falls.
- EXEC_CYC, 2000: execution wait for normal commands and data.
- LONG_CYC, 80000: execution wait for clear (0x01) and home (0x02/0x03).
- POR_CYC, 2000000: power-on wait before the init sequence (only with LCD_INIT_SEQ_EN).

Ports:
- clk, in, 1: single clock; all logic on posedge.
- rst_n, in, 1: asynchronous assert, active-low reset.
- req0_valid, in, 1: requester 0 has a byte.
- req0_rs, in, 1: 0 = command, 1 = data.
- req0_data, in, 8: byte to write.
- req0_ready, out, 1: accept strobe for requester 0.
- req1_valid, req1_rs, req1_data, req1_ready: same as requester 0, for requester 1.
- lcd_rs, out, 1: LCD register select.
- lcd_en, out, 1: LCD enable strobe.
- lcd_dat, out, 8: LCD data bus.
- busy, out, 1: high when state is not IDLE.
- init_done, out, 1: high once the controller is ready for requester traffic; stays high until reset.

## Operation
- States: POR_WAIT, INIT_ISSUE, IDLE, SETUP, PULSE, HOLD, EXEC.
- POR_WAIT and INIT_ISSUE exist only with LCD_INIT_SEQ_EN.
- IDLE:
  - If any reqN_valid is high, the arbiter grants one requester.
  - reqN_ready goes high combinationally in that same cycle. This is the accept cycle T.
  - rs and data are latched, and the state goes to SETUP.
- Arbitration is 2-way round-robin. When both requesters are valid, the one not granted last wins. The pointer resets to favour req0. A lone valid requester always wins.
- reqN_ready is low in every state other than IDLE. At most one ready is high per cycle.
- Requester rules:
  - valid must not depend on ready.
  - Once valid is raised, the requester holds valid, rs and data until accepted.
  - The block never drops an accepted byte.
- SETUP: drive lcd_rs/lcd_dat from the latch with lcd_en=0, for SETUP_CYC cycles, then go to PULSE.
- PULSE: lcd_en=1 for PULSE_CYC cycles, then go to HOLD.
- HOLD: lcd_en=0 with the bus still held, for HOLD_CYC cycles, then go to EXEC.
- EXEC:
  - Wait LONG_CYC if latched rs==0 and data[7:2]==0 and data!=0; otherwise wait EXEC_CYC. Then return to IDLE.
  - lcd_rs/lcd_dat keep their last value until the next SETUP.
- Phase timing uses one down-counter, 24 bits minimum. It is loaded with count-1 on phase entry, and the phase exits when the counter reaches 0.
- Reset, including reset mid-transaction:
  - Outputs: lcd_en=0, lcd_rs=0, lcd_dat=0, both ready=0, init_done=0. The in-flight byte is lost.
  - Internal: arbiter pointer favours req0; counter is 0.
  - State goes to POR_WAIT if LCD_INIT_SEQ_EN, otherwise IDLE.
  - busy is 1 with init, 0 without.

## Timing
- Accept at cycle T. The bus is driven from T+1.
- lcd_en rises at T+1+SETUP_CYC and falls at T+1+SETUP_CYC+PULSE_CYC.
- IDLE is re-entered at T+1+SETUP_CYC+PULSE_CYC+HOLD_CYC+wait, where wait is EXEC_CYC or LONG_CYC.
- The next accept can happen in that re-entry cycle. Back-to-back throughput is therefore 1+SETUP+PULSE+HOLD+wait cycles per byte.
- All LCD outputs are registered. Ready is the only combinational output.

## Configuration
- LCD_INIT_SEQ_EN defined:
  - After reset, wait POR_CYC in POR_WAIT.
  - Then INIT_ISSUE sends command bytes 0x38, 0x0C, 0x06, 0x01 in order. Each uses the full SETUP/PULSE/HOLD/EXEC timing; 0x01 uses LONG_CYC.
  - Requesters are never granted during init.
  - init_done rises in the first IDLE cycle.
- LCD_INIT_SEQ_EN undefined:
  - POR_WAIT and INIT_ISSUE are absent and reset enters IDLE.
  - init_done rises on the first clk edge after rst_n deasserts.

## Structure
- Shared package lcd_pkg holds:
  - the state enum;
  - CMD_CLEAR=8'h01, CMD_HOME=8'h02;
  - the init table (4 bytes) and its length;
  - the counter width constant.
- Sub-module lcd_rr_arb: 2-request round-robin arbiter with inputs valid[1:0] and advance, output grant one-hot. The pointer updates only on accept.

## Test plan
All scenarios use SETUP=2, PULSE=3, HOLD=2, EXEC=5, LONG=20, POR=10.
- Init enabled, reset release → after 10 cycles, bus shows 0x38, 0x0C, 0x06, 0x01 with rs=0, each with en high exactly 3 cycles; init_done rises 1+2+3+2+20 cycles after the 0x01 transaction starts.
- req0 sends data 0x41 (rs=1) at accept cycle T → en high over T+3..T+5; IDLE at T+13; req0_ready high only at T.
- req0 and req1 valid continuously → grants alternate 0,1,0,1; bytes are never reordered within a requester.
- Command 0x01 then 0x80 → gap between the two en falling edges is 2+20+1+2+3 cycles; 0x80 uses EXEC=5.
- rst_n low during PULSE → lcd_en drops without waiting for a clock; after release, no ready until IDLE; pending valid is then re-accepted.
- Valid held while busy → ready stays 0 until IDLE; data held stable is latched unchanged.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD1602 bus scheduler.
// Includes the state encoding, command codes, power-up init table and counter width.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_POR_WAIT,
    ST_INIT_ISSUE,
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_EXEC
  } lcd_state_e;

  localparam int CNT_W = 24;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  // Entry 0 is sent first: function set, display on, entry mode, clear.
  localparam int INIT_LEN = 4;
  localparam logic [INIT_LEN-1:0][7:0] INIT_TAB = {8'h01, 8'h06, 8'h0C, 8'h38};

  // A phase of n cycles loads n-1; a zero count still lasts one cycle.
  function automatic logic [CNT_W-1:0] cyc_load(input int unsigned n);
    return (n == 0) ? '0 : CNT_W'(n - 1);
  endfunction

  // Clear and home (0x02/0x03) need the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == CMD_CLEAR) || (data[7:1] == CMD_HOME[7:1]));
  endfunction

endpackage

// File: rtl/lcd_rr_arb.sv
// Two-request round-robin arbiter; grant is one-hot (or zero when nothing is valid).
// The priority pointer only moves when the granted request is actually accepted.
module lcd_rr_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr;  // 0 favours request 0, 1 favours request 1

  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = ptr ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (advance) begin
      ptr <= grant[0];
    end
  end

endmodule

// File: rtl/lcd_bus_sched.sv
// HD44780 8-bit bus sequencer: arbitrates two byte requesters and times rs/dat/en.
// Define LCD_INIT_SEQ_EN to add the power-on wait and the built-in init command sequence.
module lcd_bus_sched
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYC = 4,
  parameter int unsigned PULSE_CYC = 24,
  parameter int unsigned HOLD_CYC  = 4,
  parameter int unsigned EXEC_CYC  = 2000,
  parameter int unsigned LONG_CYC  = 80000,
  parameter int unsigned POR_CYC   = 2000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic       req0_rs,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic       req1_rs,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       lcd_rs,
  output logic       lcd_en,
  output logic [7:0] lcd_dat,
  output logic       busy,
  output logic       init_done
);

  localparam logic [CNT_W-1:0] SETUP_LD = cyc_load(SETUP_CYC);
  localparam logic [CNT_W-1:0] PULSE_LD = cyc_load(PULSE_CYC);
  localparam logic [CNT_W-1:0] HOLD_LD  = cyc_load(HOLD_CYC);
  localparam logic [CNT_W-1:0] EXEC_LD  = cyc_load(EXEC_CYC);
  localparam logic [CNT_W-1:0] LONG_LD  = cyc_load(LONG_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE  = 1;

`ifdef LCD_INIT_SEQ_EN
  localparam lcd_state_e       RESET_ST = ST_POR_WAIT;
  localparam logic [CNT_W-1:0] POR_LD   = cyc_load(POR_CYC);
  logic [2:0] init_idx;
`else
  localparam lcd_state_e       RESET_ST = ST_IDLE;
`endif

  lcd_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       grant;
  logic             accept;
  logic             sel_rs;
  logic [7:0]       sel_data;

  // Requesters are only served once the controller is up and sitting in IDLE.
  assign accept     = (state == ST_IDLE) && init_done && (req0_valid || req1_valid);
  assign req0_ready = accept && grant[0];
  assign req1_ready = accept && grant[1];
  assign busy       = (state != ST_IDLE);
  assign sel_rs     = grant[1] ? req1_rs   : req0_rs;
  assign sel_data   = grant[1] ? req1_data : req0_data;

  lcd_rr_arb u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   ({req1_valid, req0_valid}),
    .advance (accept),
    .grant   (grant)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RESET_ST;
      cnt       <= '0;
      lcd_rs    <= 1'b0;
      lcd_en    <= 1'b0;
      lcd_dat   <= 8'h00;
      init_done <= 1'b0;
`ifdef LCD_INIT_SEQ_EN
      init_idx  <= 3'd0;
`endif
    end else begin
`ifndef LCD_INIT_SEQ_EN
      init_done <= 1'b1;
`endif
      case (state)
`ifdef LCD_INIT_SEQ_EN
        // The counter leaves reset at 0, so the power-on wait counts up.
        ST_POR_WAIT: begin
          if (cnt == POR_LD) begin
            cnt   <= '0;
            state <= ST_INIT_ISSUE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ST_INIT_ISSUE: begin
          lcd_rs   <= 1'b0;
          lcd_dat  <= INIT_TAB[init_idx[1:0]];
          init_idx <= init_idx + 3'd1;
          cnt      <= SETUP_LD;
          state    <= ST_SETUP;
        end
`endif
        ST_IDLE: begin
          if (accept) begin
            lcd_rs  <= sel_rs;
            lcd_dat <= sel_data;
            cnt     <= SETUP_LD;
            state   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt == '0) begin
            lcd_en <= 1'b1;
            cnt    <= PULSE_LD;
            state  <= ST_PULSE;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        ST_PULSE: begin
          if (cnt == '0) begin
            lcd_en <= 1'b0;
            cnt    <= HOLD_LD;
            state  <= ST_HOLD;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        ST_HOLD: begin
          if (cnt == '0) begin
            cnt   <= is_long_cmd(lcd_rs, lcd_dat) ? LONG_LD : EXEC_LD;
            state <= ST_EXEC;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        ST_EXEC: begin
          if (cnt == '0) begin
`ifdef LCD_INIT_SEQ_EN
            if (!init_done && (init_idx != 3'(INIT_LEN))) begin
              state <= ST_INIT_ISSUE;
            end else begin
              state     <= ST_IDLE;
              init_done <= 1'b1;
            end
`else
            state <= ST_IDLE;
`endif
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bus_sched.sv
// Directed bench for lcd_bus_sched with SETUP=2, PULSE=3, HOLD=2, EXEC=5, LONG=20, POR=10.
// Inputs change just after the falling edge; outputs are sampled 1 time unit later.
module tb_lcd_bus_sched;

  localparam int unsigned SETUP = 2;
  localparam int unsigned PULSE = 3;
  localparam int unsigned HOLD  = 2;
  localparam int unsigned EXEC  = 5;
  localparam int unsigned LONG  = 20;
  localparam int unsigned POR   = 10;

`ifdef LCD_INIT_SEQ_EN
  localparam logic RST_BUSY = 1'b1;
`else
  localparam logic RST_BUSY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req0_rs = 1'b0, req0_ready;
  logic [7:0] req0_data = 8'h00;
  logic       req1_valid = 1'b0, req1_rs = 1'b0, req1_ready;
  logic [7:0] req1_data = 8'h00;
  logic       lcd_rs, lcd_en, busy, init_done;
  logic [7:0] lcd_dat;

  int n_checks = 0;
  int n_fail   = 0;

  // Clock and reset.
  always #5 clk = ~clk;

  lcd_bus_sched #(
    .SETUP_CYC (SETUP), .PULSE_CYC (PULSE), .HOLD_CYC (HOLD),
    .EXEC_CYC  (EXEC),  .LONG_CYC  (LONG),  .POR_CYC  (POR)
  ) dut (
    .clk        (clk),        .rst_n      (rst_n),
    .req0_valid (req0_valid), .req0_rs    (req0_rs),
    .req0_data  (req0_data),  .req0_ready (req0_ready),
    .req1_valid (req1_valid), .req1_rs    (req1_rs),
    .req1_data  (req1_data),  .req1_ready (req1_ready),
    .lcd_rs     (lcd_rs),     .lcd_en     (lcd_en),
    .lcd_dat    (lcd_dat),    .busy       (busy),
    .init_done  (init_done)
  );

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk); #1;
      if (!busy) done = 1;
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL wait_idle: busy still %b after 400 cycles, want 0", busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    req0_valid = 1'b1; req0_data = 8'hA5;
    #1;
    n_checks++; if (lcd_en !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %b want 0", lcd_en); end
    n_checks++; if (lcd_rs !== 1'b0) begin n_fail++; $display("FAIL reset_rs: got %b want 0", lcd_rs); end
    n_checks++; if (lcd_dat !== 8'h00) begin n_fail++; $display("FAIL reset_dat: got %h want 00", lcd_dat); end
    n_checks++; if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready0: got %b want 0", req0_ready); end
    n_checks++; if (busy !== RST_BUSY) begin n_fail++; $display("FAIL reset_busy: got %b want %b", busy, RST_BUSY); end
    n_checks++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL reset_init_done: got %b want 0", init_done); end
    req0_valid = 1'b0; req0_data = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL release_init_done: got %b want 0", init_done); end
    @(negedge clk); #1;
`ifdef LCD_INIT_SEQ_EN
    n_checks++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL first_edge_init_done: got %b want 0", init_done); end
`else
    n_checks++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL first_edge_init_done: got %b want 1", init_done); end
`endif
  endtask

`ifdef LCD_INIT_SEQ_EN
  task automatic test_init();
    logic [7:0] exp_q[$];
    int cyc = 0, width = 0, clr_cyc = -1, done_cyc = -1;
    logic prev_en = 1'b0;
    exp_q = '{8'h38, 8'h0C, 8'h06, 8'h01};
    while (done_cyc < 0 && cyc < 400) begin
      @(negedge clk); #1; cyc++;
      if (lcd_en && !prev_en) begin
        n_checks++;
        if (exp_q.size() == 0 || lcd_dat !== exp_q[0] || lcd_rs !== 1'b0) begin
          n_fail++; $display("FAIL init_byte: got rs=%b dat=%h want rs=0 next table byte", lcd_rs, lcd_dat);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (lcd_en) width++;
      if (!lcd_en && prev_en) begin
        n_checks++; if (width != 3) begin n_fail++; $display("FAIL init_en_width: got %0d want 3", width); end
        width = 0;
      end
      if (clr_cyc < 0 && lcd_dat === 8'h01) clr_cyc = cyc;
      if (init_done === 1'b1) done_cyc = cyc;
      prev_en = lcd_en;
    end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL init_count: %0d bytes missing want 0", exp_q.size()); end
    n_checks++; if (done_cyc - clr_cyc != 27) begin n_fail++; $display("FAIL init_done_delay: got %0d want 27", done_cyc - clr_cyc); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL init_busy: got %b want 0", busy); end
  endtask
`endif

  task automatic test_round_robin();
    logic [7:0] exp_q[$];
    int gexp_q[$];
    int i0 = 0, i1 = 0, cycles = 0;
    logic prev_en = 1'b0, r0, r1;
    exp_q  = '{8'h10, 8'h20, 8'h11, 8'h21};
    gexp_q = '{0, 1, 0, 1};
    @(negedge clk);
    req0_rs = 1'b1; req0_data = 8'h10; req0_valid = 1'b1;
    req1_rs = 1'b1; req1_data = 8'h20; req1_valid = 1'b1;
    while ((i0 < 2 || i1 < 2 || busy) && cycles < 200) begin
      #1;
      r0 = req0_ready; r1 = req1_ready;
      if (r0 && r1) begin
        n_checks++; n_fail++; $display("FAIL rr_one_hot: got ready0=%b ready1=%b want at most one", r0, r1);
      end
      if (r0 || r1) begin
        n_checks++;
        if (gexp_q.size() == 0 || gexp_q[0] != (r1 ? 1 : 0)) begin
          n_fail++; $display("FAIL rr_grant: got req%0d want req%0d", r1 ? 1 : 0, (gexp_q.size() != 0) ? gexp_q[0] : -1);
        end
        if (gexp_q.size() != 0) void'(gexp_q.pop_front());
      end
      if (lcd_en && !prev_en) begin
        n_checks++;
        if (exp_q.size() == 0 || lcd_dat !== exp_q[0]) begin
          n_fail++; $display("FAIL rr_byte: got %h want %h", lcd_dat, (exp_q.size() != 0) ? exp_q[0] : 8'hxx);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      prev_en = lcd_en;
      @(negedge clk); cycles++;
      if (r0) begin i0++; if (i0 == 2) req0_valid = 1'b0; else req0_data = 8'h11; end
      if (r1) begin i1++; if (i1 == 2) req1_valid = 1'b0; else req1_data = 8'h21; end
    end
    n_checks++; if (cycles >= 200) begin n_fail++; $display("FAIL rr_timeout: got %0d cycles want < 200", cycles); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rr_bytes_left: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_single_and_hold();
    logic exp_en;
    @(negedge clk);
    req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h41;
    #1;
    n_checks++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready_T: got %b want 1", req0_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_T: got %b want 0", busy); end
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 1) req0_valid = 1'b0;
      if (k == 2) begin req1_valid = 1'b1; req1_rs = 1'b0; req1_data = 8'h66; end
      if (k == 14) req1_valid = 1'b0;
      #1;
      exp_en = (k >= 3 && k <= 5);
      n_checks++; if (lcd_en !== exp_en) begin n_fail++; $display("FAIL single_en T+%0d: got %b want %b", k, lcd_en, exp_en); end
      n_checks++; if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL single_ready0 T+%0d: got %b want 0", k, req0_ready); end
      n_checks++; if (req1_ready !== (k == 13)) begin n_fail++; $display("FAIL hold_ready1 T+%0d: got %b want %b", k, req1_ready, k == 13); end
      n_checks++; if (busy !== (k != 13)) begin n_fail++; $display("FAIL single_busy T+%0d: got %b want %b", k, busy, k != 13); end
      n_checks++;
      if (lcd_dat !== ((k == 14) ? 8'h66 : 8'h41) || lcd_rs !== (k != 14)) begin
        n_fail++; $display("FAIL single_bus T+%0d: got rs=%b dat=%h want rs=%b dat=%h", k, lcd_rs, lcd_dat, k != 14, (k == 14) ? 8'h66 : 8'h41);
      end
    end
    wait_idle();
  endtask

  task automatic test_exec_select();
    logic       rs_t [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] dat_t[6] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h01, 8'h00};
    int         wt_t [6] = '{20, 20, 20, 5, 5, 5};
    int cnt;
    for (int r = 0; r < 6; r++) begin
      @(negedge clk);
      req1_valid = 1'b1; req1_rs = rs_t[r]; req1_data = dat_t[r];
      #1;
      n_checks++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL exec_ready row%0d: got %b want 1", r, req1_ready); end
      cnt = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        req1_valid = 1'b0;
        #1;
        if (!busy) break;
        cnt++;
      end
      n_checks++;
      if (cnt != 7 + wt_t[r]) begin
        n_fail++; $display("FAIL exec_len rs=%b dat=%h: got %0d busy cycles want %0d", rs_t[r], dat_t[r], cnt, 7 + wt_t[r]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc = 0, nfall = 0, fall0 = -1, fall1 = -1, idle_cyc = -1, stage = 0;
    logic prev_en = 1'b0, r0;
    @(negedge clk);
    req0_valid = 1'b1; req0_rs = 1'b0; req0_data = 8'h01;
    while (idle_cyc < 0 && cyc < 150) begin
      #1;
      r0 = req0_ready;
      if (!lcd_en && prev_en) begin
        if (nfall == 0) fall0 = cyc;
        else begin
          fall1 = cyc;
          n_checks++; if (lcd_dat !== 8'h80) begin n_fail++; $display("FAIL b2b_second_byte: got %h want 80", lcd_dat); end
        end
        nfall++;
      end
      if (nfall == 2 && !busy) idle_cyc = cyc;
      prev_en = lcd_en;
      @(negedge clk); cyc++;
      if (r0) begin
        if (stage == 0) req0_data = 8'h80; else req0_valid = 1'b0;
        stage++;
      end
    end
    n_checks++; if (fall1 - fall0 != 28) begin n_fail++; $display("FAIL b2b_gap: got %0d want 28", fall1 - fall0); end
    n_checks++; if (idle_cyc - fall1 != 7) begin n_fail++; $display("FAIL b2b_short_exec: got %0d want 7", idle_cyc - fall1); end
  endtask

  task automatic test_reset_mid();
    int dly = -1;
    bit seen_en = 0;
    @(negedge clk);
    req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h41;
    #1;
    n_checks++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_accept: got %b want 1", req0_ready); end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_rs = 1'b1; req1_data = 8'h55;
    for (int i = 0; i < 20 && !seen_en; i++) begin
      @(negedge clk); #1;
      if (lcd_en) seen_en = 1;
    end
    n_checks++; if (!seen_en) begin n_fail++; $display("FAIL rmid_pulse: en never rose, want 1"); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (lcd_en !== 1'b0) begin n_fail++; $display("FAIL rmid_en: got %b want 0", lcd_en); end
    n_checks++; if (lcd_dat !== 8'h00 || lcd_rs !== 1'b0) begin n_fail++; $display("FAIL rmid_bus: got rs=%b dat=%h want 0/00", lcd_rs, lcd_dat); end
    n_checks++; if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_ready1: got %b want 0", req1_ready); end
    n_checks++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL rmid_init_done: got %b want 0", init_done); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++; if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_release_ready: got %b want 0", req1_ready); end
    for (int i = 1; i <= 300 && dly < 0; i++) begin
      @(negedge clk); #1;
      if (req1_ready) begin
        dly = i;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_ready_busy: got busy=%b want 0", busy); end
      end
    end
`ifdef LCD_INIT_SEQ_EN
    n_checks++; if (dly < 0) begin n_fail++; $display("FAIL rmid_reaccept: got no ready want one"); end
`else
    n_checks++; if (dly != 1) begin n_fail++; $display("FAIL rmid_reaccept: got delay %0d want 1", dly); end
`endif
    @(negedge clk);
    req1_valid = 1'b0;
    #1;
    n_checks++; if (lcd_dat !== 8'h55 || lcd_rs !== 1'b1) begin n_fail++; $display("FAIL rmid_resend: got rs=%b dat=%h want 1/55", lcd_rs, lcd_dat); end
    wait_idle();
  endtask

  initial begin
    test_reset();
`ifdef LCD_INIT_SEQ_EN
    test_init();
`endif
    test_round_robin();
    test_single_and_hold();
    test_exec_select();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
